// File: rtl/rvh_noc_pkg.sv
// Shared NoC router types and sizing constants used by the output-port credit logic.
package rvh_noc_pkg;

  localparam int VC_ID_NUM_MAX   = 6;
  localparam int VC_ID_NUM_MAX_W = $clog2(VC_ID_NUM_MAX);
  localparam int VC_DEPTH_MAX    = 4;
  localparam int RT_VC_ID        = VC_ID_NUM_MAX - 1;
  localparam int VC_CREDIT_CNT_W = $clog2(VC_DEPTH_MAX + 1);

  typedef logic [VC_CREDIT_CNT_W-1:0] vc_credit_cnt_t;
  typedef logic [VC_ID_NUM_MAX_W-1:0] vc_id_t;

  typedef struct packed {
    logic common_vld;
    logic rt_vld;
  } vc_select_vld_t;

  typedef struct packed {
    vc_id_t common_vc_id;
    vc_id_t rt_vc_id;
  } vc_select_vc_id_t;

endpackage

// File: rtl/output_port_vc_credit_tracker_rr.sv
// Combinational round-robin pick: first set request at or after start_i, wrapping at N-1.
module rr_first_set_select #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             vld_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [IDX_W:0] off;
  logic [IDX_W:0] sum;

  // Rotate so start_i lands on bit 0, priority-encode, then rotate the index back.
  always_comb begin
    req_dbl = {req_i, req_i} >> start_i;
    req_rot = req_dbl[N-1:0];
    off     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) off = (IDX_W + 1)'(i);
    end
    sum = {1'b0, start_i} + off;
    if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
    vld_o = |req_i;
    idx_o = vld_o ? sum[IDX_W-1:0] : '0;
  end

endmodule

// File: rtl/output_port_vc_credit_tracker.sv
// Tracks free flit slots per downstream VC and offers one round-robin common VC plus the RT VC.
module output_port_vc_credit_tracker
  import rvh_noc_pkg::*;
#(
  parameter int VC_NUM   = VC_ID_NUM_MAX,
  parameter int VC_DEPTH = VC_DEPTH_MAX,
  parameter int CNT_W    = $clog2(VC_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tx_flit_vld_i,
  input  logic [VC_ID_NUM_MAX_W-1:0] tx_flit_vc_id_i,
  input  logic                    rx_lcrd_vld_i,
  input  logic [VC_ID_NUM_MAX_W-1:0] rx_lcrd_vc_id_i,
  output vc_select_vld_t          vc_select_vld_o,
  output vc_select_vc_id_t        vc_select_vc_id_o,
  output logic [VC_NUM*CNT_W-1:0] credit_cnt_o,
  output logic [1:0]              err_o
);

  localparam int             NC    = VC_NUM - 1;
  localparam vc_id_t         RT_ID = vc_id_t'(VC_NUM - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(VC_DEPTH);

  logic [CNT_W-1:0] cnt_q [VC_NUM];
  logic [CNT_W-1:0] cnt_d [VC_NUM];
  vc_id_t           rr_ptr_q, rr_ptr_d;
  logic [1:0]       err_q, err_d;
  vc_select_vld_t   vld_q, vld_d;
  vc_select_vc_id_t id_q, id_d;

  logic          tx_ok, lcrd_ok, dec, inc, unf, ovf;
  logic [NC-1:0] common_req;
  logic          sel_vld;
  vc_id_t        sel_idx;

  // Events with an out-of-range VC id never touch a counter; they only raise the error flag.
  always_comb begin
    tx_ok   = tx_flit_vld_i && (int'(tx_flit_vc_id_i) < VC_NUM);
    lcrd_ok = rx_lcrd_vld_i && (int'(rx_lcrd_vc_id_i) < VC_NUM);
    unf     = tx_flit_vld_i && !tx_ok;
    ovf     = rx_lcrd_vld_i && !lcrd_ok;
    dec     = 1'b0;
    inc     = 1'b0;
    for (int v = 0; v < VC_NUM; v++) begin
      dec      = tx_ok && (tx_flit_vc_id_i == vc_id_t'(v));
      inc      = lcrd_ok && (rx_lcrd_vc_id_i == vc_id_t'(v));
      cnt_d[v] = cnt_q[v];
      if (dec && !inc) begin
        if (cnt_q[v] == '0) unf = 1'b1;
        else cnt_d[v] = cnt_q[v] - CNT_W'(1);
      end else if (inc && !dec) begin
        if (cnt_q[v] == FULL) ovf = 1'b1;
        else cnt_d[v] = cnt_q[v] + CNT_W'(1);
      end
    end
    err_d = err_q | {ovf, unf};
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (tx_ok && (int'(tx_flit_vc_id_i) < NC)) begin
      if (int'(tx_flit_vc_id_i) == NC - 1) rr_ptr_d = '0;
      else rr_ptr_d = tx_flit_vc_id_i + vc_id_t'(1);
    end
  end

  // Selection looks at next-state counters so a send that empties a VC withdraws it immediately.
  always_comb begin
    for (int c = 0; c < NC; c++) begin
      common_req[c] = (cnt_d[c] != '0);
    end
  end

  rr_first_set_select #(
    .N     (NC),
    .IDX_W (VC_ID_NUM_MAX_W)
  ) u_rr_sel (
    .req_i   (common_req),
    .start_i (rr_ptr_d),
    .vld_o   (sel_vld),
    .idx_o   (sel_idx)
  );

  always_comb begin
    vld_d.common_vld   = sel_vld;
    vld_d.rt_vld       = (cnt_d[VC_NUM-1] != '0);
    id_d.common_vc_id  = sel_idx;
    id_d.rt_vc_id      = RT_ID;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) cnt_q[v] <= FULL;
      rr_ptr_q <= '0;
      err_q    <= '0;
      vld_q    <= '{common_vld: 1'b1, rt_vld: 1'b1};
      id_q     <= '{common_vc_id: '0, rt_vc_id: RT_ID};
    end else begin
      for (int v = 0; v < VC_NUM; v++) cnt_q[v] <= cnt_d[v];
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      id_q     <= id_d;
    end
  end

  for (genvar g = 0; g < VC_NUM; g++) begin : g_cnt_out
    assign credit_cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign vc_select_vld_o   = vld_q;
  assign vc_select_vc_id_o = id_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_output_port_vc_credit_tracker.sv
// Directed and randomized checks of the credit tracker against a plain credit-count model.
module tb_output_port_vc_credit_tracker;
  import rvh_noc_pkg::*;

  localparam int NVC   = 6;
  localparam int NCOM  = NVC - 1;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 txVld;
  logic [2:0]           txId;
  logic                 lcrdVld;
  logic [2:0]           lcrdId;
  vc_select_vld_t       selVld;
  vc_select_vc_id_t     selId;
  logic [NVC*CW-1:0]    creditCnt;
  logic [1:0]           err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: free slots per VC, round-robin start point and sticky error bits.
  int credits [NVC];
  int rrPtr;
  bit errUnder, errOver;

  output_port_vc_credit_tracker dut (
    .clk               (clk),
    .rst               (rst),
    .tx_flit_vld_i     (txVld),
    .tx_flit_vc_id_i   (txId),
    .rx_lcrd_vld_i     (lcrdVld),
    .rx_lcrd_vc_id_i   (lcrdId),
    .vc_select_vld_o   (selVld),
    .vc_select_vc_id_o (selId),
    .credit_cnt_o      (creditCnt),
    .err_o             (err)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int v = 0; v < NVC; v++) credits[v] = DEPTH;
    rrPtr    = 0;
    errUnder = 1'b0;
    errOver  = 1'b0;
  endfunction

  // One clock of credit accounting written straight from the protocol rules.
  function automatic void modelStep(input bit tv, input int tid, input bit lv, input int lid);
    bit txOk   = tv && (tid < NVC);
    bit lcrdOk = lv && (lid < NVC);
    if (tv && !txOk) errUnder = 1'b1;
    if (lv && !lcrdOk) errOver = 1'b1;
    if (txOk && lcrdOk && tid == lid) begin
      // send and return on the same VC cancel out
    end else begin
      if (txOk) begin
        if (credits[tid] == 0) errUnder = 1'b1;
        else credits[tid] -= 1;
      end
      if (lcrdOk) begin
        if (credits[lid] == DEPTH) errOver = 1'b1;
        else credits[lid] += 1;
      end
    end
    if (txOk && tid < NCOM) rrPtr = (tid + 1) % NCOM;
  endfunction

  task automatic checkOutput();
    bit          expVld = 1'b0;
    int          expId  = 0;
    logic [31:0] expCnt = '0;
    for (int k = 0; k < NCOM; k++) begin
      int c = (rrPtr + k) % NCOM;
      if (!expVld && credits[c] > 0) begin
        expVld = 1'b1;
        expId  = c;
      end
    end
    for (int v = 0; v < NVC; v++) expCnt[v*CW +: CW] = CW'(credits[v]);
    checkEq("common_vld", 32'(selVld.common_vld), 32'(expVld));
    checkEq("rt_vld", 32'(selVld.rt_vld), 32'(credits[NVC-1] != 0));
    checkEq("common_id", 32'(selId.common_vc_id), 32'(expId));
    checkEq("rt_id", 32'(selId.rt_vc_id), 32'd5);
    checkEq("credit_cnt", 32'(creditCnt), expCnt);
    checkEq("err", 32'(err), {30'd0, errOver, errUnder});
  endtask

  task automatic applyStimulus(input bit tv, input int tid, input bit lv, input int lid);
    @(negedge clk);
    rst     = 1'b0;
    txVld   = tv;
    txId    = 3'(tid);
    lcrdVld = lv;
    lcrdId  = 3'(lid);
    @(posedge clk);
    modelStep(tv, tid, lv, lid);
    #1;
    checkOutput();
  endtask

  task automatic resetDut(input bit tv, input int tid, input bit lv, input int lid);
    @(negedge clk);
    rst     = 1'b1;
    txVld   = tv;
    txId    = 3'(tid);
    lcrdVld = lv;
    lcrdId  = 3'(lid);
    @(posedge clk);
    modelReset();
    #1;
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; txVld = 1'b0; txId = '0; lcrdVld = 1'b0; lcrdId = '0;
    modelReset();

    resetDut(0, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    checkEq("idle_all_cnt4", 32'(creditCnt), 32'o444444);
    checkEq("idle_vld", 32'(selVld), 32'b11);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 2, 0, 0);
      checkEq("vc2_burst_common_id", 32'(selId.common_vc_id), 32'd3);
    end
    checkEq("vc2_drained", 32'(creditCnt[2*CW +: CW]), 32'd0);

    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 1, 1);
    checkEq("vc1_same_cycle_cnt", 32'(creditCnt[1*CW +: CW]), 32'd2);
    checkEq("vc1_same_cycle_err", 32'(err), 32'd0);

    for (int c = 0; c < NCOM; c++) begin
      for (int n = 0; n < DEPTH && credits[c] > 0; n++) applyStimulus(1, c, 0, 0);
    end
    checkEq("common_drained_vld", 32'(selVld.common_vld), 32'd0);
    checkEq("common_drained_id", 32'(selId.common_vc_id), 32'd0);
    applyStimulus(0, 0, 1, 3);
    checkEq("vc3_credit_vld", 32'(selVld.common_vld), 32'd1);
    checkEq("vc3_credit_id", 32'(selId.common_vc_id), 32'd3);

    for (int i = 0; i < 4; i++) applyStimulus(1, 5, 0, 0);
    checkEq("rt_empty_vld", 32'(selVld.rt_vld), 32'd0);
    checkEq("rt_no_err_yet", 32'(err), 32'd0);
    applyStimulus(1, 5, 0, 0);
    checkEq("rt_underflow_err", 32'(err), 32'b01);
    applyStimulus(0, 0, 0, 0);
    checkEq("rt_underflow_sticky", 32'(err), 32'b01);

    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    checkEq("vc0_overflow_cnt", 32'(creditCnt[0 +: CW]), 32'd4);
    checkEq("vc0_overflow_err", 32'(err[1]), 32'd1);

    applyStimulus(1, 2, 1, 4);
    resetDut(1, 3, 1, 1);
    checkEq("midburst_reset_cnt", 32'(creditCnt), 32'o444444);
    checkEq("midburst_reset_err", 32'(err), 32'd0);

    applyStimulus(1, 7, 0, 0);
    checkEq("bad_tx_id_err", 32'(err), 32'b01);
    applyStimulus(0, 0, 1, 6);
    checkEq("bad_lcrd_id_err", 32'(err), 32'b11);
    checkEq("bad_id_cnt_untouched", 32'(creditCnt), 32'o444444);
    resetDut(0, 0, 0, 0);

    // Randomized traffic with occasional illegal ids and periodic resets.
    for (int i = 0; i < 400; i++) begin
      bit tv = 1'($urandom_range(0, 1));
      bit lv = 1'($urandom_range(0, 1));
      int tid = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
      int lid = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
      if (i % 100 == 99) resetDut(tv, tid, lv, lid);
      else applyStimulus(tv, tid, lv, lid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
